// File: rtl/ins_encoder.sv
// rtl/ins_encoder.sv - two-stage RV32I field-to-word encoder with word addressing
// Optional immediate range checking is enabled by defining INSENC_RANGE_CHECK_EN.
module ins_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        instruction_type,
  input  logic [6:0]        opcode,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [31:0]       NOP      = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] BASE_VAL = ADDR_W'(BASE_ADDR);

  logic              s1_valid;
  logic [2:0]        s1_type;
  logic [6:0]        s1_opcode;
  logic [6:0]        s1_funct7;
  logic [2:0]        s1_funct3;
  logic [4:0]        s1_rs1;
  logic [4:0]        s1_rs2;
  logic [4:0]        s1_rd;
  logic [31:0]       s1_imm;
  logic              s2_valid;
  logic [ADDR_W-1:0] addr_ctr;

  logic        advance;
  logic        accept;
  logic        handoff;
  logic [31:0] enc_word;
  logic        enc_bad;

  assign advance   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || advance;
  assign accept    = in_valid && in_ready;
  assign handoff   = s2_valid && out_ready;
  assign out_valid = s2_valid;

`ifdef INSENC_RANGE_CHECK_EN
  // Each range check is "upper bits are a pure sign extension".
  logic i_ok, u_ok, b_ok, j_ok;
  assign i_ok = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign u_ok = !(|s1_imm[11:0]);
  assign b_ok = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
  assign j_ok = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];
`endif

  always_comb begin
    enc_word = NOP;
    enc_bad  = 1'b0;
    case (s1_type)
      3'd1: begin
        if (s1_opcode == 7'b0110011 || s1_opcode == 7'b1110011)
          enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
        else
          enc_bad = 1'b1;
      end
      3'd2: enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, 7'b0010011};
      3'd3: enc_word = {s1_imm[31:12], s1_rd, 7'b0110111};
      3'd4: enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                        s1_imm[4:1], s1_imm[11], 7'b1100011};
      3'd5: enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, 7'b1100111};
      3'd6: enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                        s1_rd, 7'b1101111};
      default: enc_bad = 1'b1;
    endcase
`ifdef INSENC_RANGE_CHECK_EN
    case (s1_type)
      3'd2, 3'd5: if (!i_ok) enc_bad = 1'b1;
      3'd3:       if (!u_ok) enc_bad = 1'b1;
      3'd4:       if (!b_ok) enc_bad = 1'b1;
      3'd6:       if (!j_ok) enc_bad = 1'b1;
      default: ;
    endcase
`endif
    if (enc_bad)
      enc_word = NOP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_instr <= 32'd0;
      out_addr  <= BASE_VAL;
      addr_ctr  <= BASE_VAL;
      err       <= 1'b0;
      count     <= '0;
      s1_type   <= 3'd0;
      s1_opcode <= 7'd0;
      s1_funct7 <= 7'd0;
      s1_funct3 <= 3'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_rd     <= 5'd0;
      s1_imm    <= 32'd0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_type   <= instruction_type;
        s1_opcode <= opcode;
        s1_funct7 <= funct7;
        s1_funct3 <= funct3;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_rd     <= rd;
        s1_imm    <= imm;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      // The encoded word and its address are frozen in S2 until handed off.
      if (advance) begin
        s2_valid  <= 1'b1;
        out_instr <= enc_word;
        out_addr  <= addr_ctr;
        addr_ctr  <= addr_ctr + 1'b1;
        if (enc_bad)
          err <= 1'b1;
      end else if (handoff) begin
        s2_valid <= 1'b0;
      end

      if (handoff && !(&count))
        count <= count + 1'b1;
    end
  end

endmodule
